weight_bram_loader: RTL
=======================

# weight_bram_loader

Write-side front end for the 16-bank weight BRAM array. Accepts a valid/ready word stream from the weight DMA/host path and scatters it round-robin across the banks: word k goes to bank k mod NUM_BRAMS at address base_addr + k / NUM_BRAMS. It drives the array's one-hot write enables and its flattened write address and write data buses directly. It signals completion so the layer scheduler can issue start_conv or start_transconv afterwards.

## Interface
- DW, 16, weight word width.
- NUM_BRAMS, 16, number of banks; must be a power of two.
- ADDR_WIDTH, 11, per-bank address width.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first row address; captured on start.
- num_rows  in  ADDR_WIDTH+1  rows per bank; total words = num_rows*NUM_BRAMS; captured on start.
- s_valid  in  1  stream word valid.
- s_data  in  DW (signed)  stream word.
- s_last  in  1  marks the final word of the stream.
- s_ready  out  1  loader accepts a word.
- w_we  out  NUM_BRAMS  one-hot bank write enable.
- w_addr_wr_flat  out  NUM_BRAMS*ADDR_WIDTH  bank write addresses.
- w_din_flat  out  NUM_BRAMS*DW (signed)  bank write data.
- busy  out  1  high from start acceptance until DONE exits.
- done  out  1  one-cycle completion pulse.
- err  out  1  framing error flag; sticky until the next accepted start.

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start=1 with num_rows>0: capture base_addr and num_rows, clear lane, row and err, go to LOAD.
  - start=1 with num_rows=0: go to DONE; no writes are issued.
- LOAD:
  - s_ready=1 in this state only.
  - A beat is accepted when s_valid & s_ready.
  - Each accepted beat writes to bank `lane` at address base_addr+row.
  - After each beat, lane increments; when lane reaches NUM_BRAMS-1 it wraps to 0 and row increments.
- Address arithmetic: base_addr+row is computed modulo 2^ADDR_WIDTH, so an overflow wraps to bank address 0 with no error.
- Load end: the beat with row=num_rows-1 and lane=NUM_BRAMS-1 is the final beat. Accepting it moves LOAD to DRAIN.
- DRAIN: lasts one cycle, then DONE.
- DONE: lasts one cycle with done=1, then IDLE.
- Bus drive: all lanes of w_addr_wr_flat carry the same registered address, and all lanes of w_din_flat carry the same registered data. Only w_we selects the bank.
- start outside IDLE is ignored.
- Reset values: s_ready, w_we, w_addr_wr_flat, w_din_flat, busy, done and err are all 0; state is IDLE.
- Reset mid-load: all state clears and no further writes occur. Banks keep whatever was already written.

## Timing
- Write latency: a beat accepted at edge t appears on w_we/addr/din during cycle t+1. That is one registered stage; the write lands in the bank at edge t+1.
- w_we is 0 in every cycle that follows a non-accepting cycle.
- Final beat accepted at edge t:
  - t+1: state DRAIN, final w_we high, s_ready=0.
  - t+2: done=1.
  - t+3: IDLE, busy=0.
- Throughput: one word per cycle while s_valid stays high.
- Idle cycles (s_valid=0) stall the counters with no penalty.
- start is captured at edge t; s_ready rises in cycle t+1.

## Configuration
- WLOAD_LAST_CHECK_EN defined:
  - s_last accepted on a non-final beat: that word is written, err is set, and the state goes to DRAIN (early terminate).
  - Final beat accepted without s_last: the load completes normally and err is set.
- WLOAD_LAST_CHECK_EN undefined: s_last is ignored and err is tied to 0.

## Structure
- Shared package weight_load_pkg holds:
  - the state encoding (IDLE=2'd0, LOAD=2'd1, DRAIN=2'd2, DONE=2'd3);
  - LANE_W = log2(NUM_BRAMS);
  - default DW, NUM_BRAMS and ADDR_WIDTH constants, shared with the weight BRAM top.
- One sub-module, wload_lane_counter, holds lane/row counting, wrap and final-beat detection. It outputs lane, row and is_final.
- FSM, output registers and error logic live in the top module.

## Test plan
- Basic load: reset; start with base_addr=0, num_rows=2; stream 32 words 0..31 continuously with s_last on word 31.
  - Bank i address 0 holds i; bank i address 1 holds 16+i.
  - done is seen 2 cycles after the last acceptance; err=0.
- Backpressure gaps: same load with s_valid toggling every other cycle.
  - Identical bank contents; w_we is high only in cycles after accepted beats.
- Address wrap: base_addr=2047, num_rows=2.
  - Row 0 is written at 2047 and row 1 at address 0 of every bank.
- Zero length: num_rows=0 start.
  - No w_we; done pulses 1 cycle after start; busy high for one cycle.
- Framing error (macro on): s_last asserted on word 5 of a 32-word load.
  - Words 0..5 are written; err=1 and done follow.
  - A subsequent start clears err.
- Mid-load reset: assert rst_n=0 after word 10.
  - All outputs are 0 immediately; after release, a new start loads normally from lane 0.

Source files
------------

// File: rtl/weight_load_pkg.sv
// Shared constants and FSM encoding for the weight BRAM write-side loader.
`timescale 1ns/1ps
package weight_load_pkg;

  localparam int unsigned DEF_DW         = 16;
  localparam int unsigned DEF_NUM_BRAMS  = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 11;
  localparam int unsigned LANE_W         = $clog2(DEF_NUM_BRAMS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wl_state_e;

endpackage

// File: rtl/wload_lane_counter.sv
// Lane/row position of the next stream beat, with a registered final-beat flag.
`timescale 1ns/1ps
module wload_lane_counter
  import weight_load_pkg::*;
#(
  parameter int unsigned NUM_BRAMS  = DEF_NUM_BRAMS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LW         = $clog2(NUM_BRAMS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [ADDR_WIDTH:0]   num_rows,
  output logic [LW-1:0]         lane,
  output logic [ADDR_WIDTH:0]   row,
  output logic                  is_final
);

  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_BRAMS - 1);

  logic [LW-1:0]       lane_q, lane_d;
  logic [ADDR_WIDTH:0] row_q, row_d;
  logic                is_final_q, is_final_d;

  // Final flag is recomputed from the post-advance position; never final right after clear.
  always_comb begin
    lane_d     = lane_q;
    row_d      = row_q;
    is_final_d = is_final_q;
    if (clear) begin
      lane_d     = '0;
      row_d      = '0;
      is_final_d = 1'b0;
    end else if (advance) begin
      if (lane_q == LAST_LANE) begin
        lane_d = '0;
        row_d  = row_q + (ADDR_WIDTH+1)'(1);
      end else begin
        lane_d = lane_q + LW'(1);
      end
      is_final_d = (lane_d == LAST_LANE) && (row_d == (num_rows - (ADDR_WIDTH+1)'(1)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q     <= '0;
      row_q      <= '0;
      is_final_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      row_q      <= row_d;
      is_final_q <= is_final_d;
    end
  end

  assign lane     = lane_q;
  assign row      = row_q;
  assign is_final = is_final_q;

endmodule

// File: rtl/weight_bram_loader.sv
// Scatters a valid/ready weight stream round-robin across the BRAM banks.
// Optional s_last framing check enabled by defining WLOAD_LAST_CHECK_EN.
`timescale 1ns/1ps
module weight_bram_loader
  import weight_load_pkg::*;
#(
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned NUM_BRAMS  = DEF_NUM_BRAMS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic [ADDR_WIDTH:0]                 num_rows,
  input  logic                                s_valid,
  input  logic signed [DW-1:0]                s_data,
  input  logic                                s_last,
  output logic                                s_ready,
  output logic [NUM_BRAMS-1:0]                w_we,
  output logic [NUM_BRAMS*ADDR_WIDTH-1:0]     w_addr_wr_flat,
  output logic signed [NUM_BRAMS*DW-1:0]      w_din_flat,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  localparam int unsigned LW = $clog2(NUM_BRAMS);

  wl_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH:0]     rows_q, rows_d;
  logic                    s_ready_q, s_ready_d;
  logic [NUM_BRAMS-1:0]    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic signed [DW-1:0]    din_q, din_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [LW-1:0]           lane;
  logic [ADDR_WIDTH:0]     row;
  logic                    is_final;

  logic accept_c, start_ok_c, end_load_c, err_hit_c;

  assign accept_c   = s_valid & s_ready_q;
  assign start_ok_c = (state_q == ST_IDLE) & start;

`ifdef WLOAD_LAST_CHECK_EN
  // Early s_last terminates the load; a missing s_last on the final beat only flags.
  assign end_load_c = accept_c & (is_final | s_last);
  assign err_hit_c  = accept_c & (is_final ^ s_last);
`else
  logic unused_last;
  assign unused_last = s_last;
  assign end_load_c  = accept_c & is_final;
  assign err_hit_c   = 1'b0;
`endif

  wload_lane_counter #(
    .NUM_BRAMS  (NUM_BRAMS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LW         (LW)
  ) u_lane_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok_c),
    .advance  (accept_c),
    .num_rows (rows_q),
    .lane     (lane),
    .row      (row),
    .is_final (is_final)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (num_rows == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD:  if (end_load_c) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; status flags track the next state so they are registered.
  always_comb begin
    base_d    = base_q;
    rows_d    = rows_q;
    addr_d    = addr_q;
    din_d     = din_q;
    we_d      = '0;
    err_d     = err_q;
    s_ready_d = (state_d == ST_LOAD);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    if (start_ok_c) begin
      base_d = base_addr;
      rows_d = num_rows;
      err_d  = 1'b0;
    end else if (err_hit_c) begin
      err_d = 1'b1;
    end
    if (accept_c) begin
      we_d   = NUM_BRAMS'(1) << lane;
      addr_d = base_q + ADDR_WIDTH'(row);
      din_d  = s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      rows_q    <= '0;
      s_ready_q <= 1'b0;
      we_q      <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      base_q    <= base_d;
      rows_q    <= rows_d;
      s_ready_q <= s_ready_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign s_ready        = s_ready_q;
  assign w_we           = we_q;
  assign w_addr_wr_flat = {NUM_BRAMS{addr_q}};
  assign w_din_flat     = {NUM_BRAMS{din_q}};
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule
